// File: rtl/trigger_txn_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : trigger_txn_sequencer_if
// Brief   : Command/response bundle between the trigger sequencer and the
//           bus initiator command port.
// Revision: 1.0 - initial release
// ============================================================================
interface trigger_txn_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/trigger_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : trigger_txn_sequencer
// Brief   : Debounces the trigger button; each press issues a write of
//           WR_DATA to TGT_ADDR then a readback, shows the read data on leds
//           and raises a sticky err on mismatch. Optional response timeout
//           enabled by `define TRIG_SEQ_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module trigger_txn_sequencer #(
    parameter int                 ADDR_W       = 16,
    parameter int                 DATA_W       = 8,
    parameter logic [ADDR_W-1:0]  TGT_ADDR     = ADDR_W'(16'h8010),
    parameter logic [DATA_W-1:0]  WR_DATA      = DATA_W'(8'hA5),
    parameter int                 DEBOUNCE_CYC = 4,
    parameter int                 RSP_TIMEOUT  = 4096
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  btn_trigger,
    trigger_txn_sequencer_if.master    bus,
    output logic [DATA_W-1:0]          leds,
    output logic                       busy,
    output logic                       err
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0] c_db_last = DB_W'(DEBOUNCE_CYC - 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_wr_cmd  = 3'd1;
    localparam logic [2:0] c_st_wr_wait = 3'd2;
    localparam logic [2:0] c_st_rd_cmd  = 3'd3;
    localparam logic [2:0] c_st_rd_wait = 3'd4;

    logic [DB_W-1:0]   r_db_cnt;
    logic              r_stable;
    logic              r_stable_d;
    logic              w_press;
    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic              w_in_wait;
    logic              w_timeout;
    logic [DATA_W-1:0] r_leds;
    logic              r_err;

    logic              w_cmd_valid;
    logic              w_cmd_write;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic [DATA_W-1:0] w_cmd_wdata;
    logic              w_busy;

    // The raw level must disagree with the accepted level for DEBOUNCE_CYC
    // consecutive cycles before it is taken; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_cnt   <= '0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            if (btn_trigger != r_stable) begin
                if (r_db_cnt == c_db_last) begin
                    r_stable <= btn_trigger;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_press   = r_stable & ~r_stable_d;
    assign w_in_wait = (r_state == c_st_wr_wait) || (r_state == c_st_rd_wait);

`ifdef TRIG_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(RSP_TIMEOUT + 1);
    localparam logic [TO_W-1:0] c_to_last = TO_W'(RSP_TIMEOUT - 1);

    logic [TO_W-1:0] r_to_cnt;

    // Restarts from zero on every entry into a wait state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_in_wait && (w_next == r_state)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_timeout = w_in_wait && !bus.rsp_valid && (r_to_cnt == c_to_last);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:    if (w_press) w_next = c_st_wr_cmd;
            c_st_wr_cmd:  if (bus.cmd_ready) w_next = c_st_wr_wait;
            c_st_wr_wait: begin
                if (bus.rsp_valid)  w_next = c_st_rd_cmd;
                else if (w_timeout) w_next = c_st_idle;
            end
            c_st_rd_cmd:  if (bus.cmd_ready) w_next = c_st_rd_wait;
            c_st_rd_wait: if (bus.rsp_valid || w_timeout) w_next = c_st_idle;
            default:      w_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_cmd_valid = 1'b0;
        w_cmd_write = 1'b0;
        w_cmd_addr  = '0;
        w_cmd_wdata = '0;
        w_busy      = (r_state != c_st_idle);
        case (r_state)
            c_st_wr_cmd: begin
                w_cmd_valid = 1'b1;
                w_cmd_write = 1'b1;
                w_cmd_addr  = TGT_ADDR;
                w_cmd_wdata = WR_DATA;
            end
            c_st_rd_cmd: begin
                w_cmd_valid = 1'b1;
                w_cmd_addr  = TGT_ADDR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_leds <= '0;
            r_err  <= 1'b0;
        end else if ((r_state == c_st_rd_wait) && bus.rsp_valid) begin
            r_leds <= bus.rsp_rdata;
            r_err  <= r_err | (bus.rsp_rdata != WR_DATA);
        end else if (w_timeout) begin
            r_err  <= 1'b1;
        end
    end

    assign bus.cmd_valid = w_cmd_valid;
    assign bus.cmd_write = w_cmd_write;
    assign bus.cmd_addr  = w_cmd_addr;
    assign bus.cmd_wdata = w_cmd_wdata;
    assign busy          = w_busy;
    assign leds          = r_leds;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_trigger_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_trigger_txn_sequencer
// Brief   : Self-checking bench for trigger_txn_sequencer with a behavioural
//           model of leds/err and a handshake-counting bus responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_trigger_txn_sequencer;
    localparam int          ADDR_W = 16;
    localparam int          DATA_W = 8;
    localparam int          DB     = 4;
    localparam int          TO     = 16;
    localparam logic [15:0] ADDR   = 16'h8010;
    localparam logic [7:0]  WD     = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_trigger = 1'b0;
    logic [7:0] leds;
    logic       busy;
    logic       err;

    trigger_txn_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    trigger_txn_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TGT_ADDR(ADDR), .WR_DATA(WD),
        .DEBOUNCE_CYC(DB), .RSP_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .btn_trigger(btn_trigger), .bus(bus),
        .leds(leds), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int valid_cycles = 0;
    int hs_count = 0;
    logic [7:0] exp_leds = 8'h00;
    logic       exp_err  = 1'b0;

    // Mid-cycle view: ready/valid both high here means a handshake at the next edge.
    always @(negedge clk) begin
        if (!rst && bus.cmd_valid) begin
            valid_cycles++;
            if (bus.cmd_ready) hs_count++;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        btn_trigger = 1'b1;
        repeat (DB + 2) cycle();
        btn_trigger = 1'b0;
        repeat (DB + 2) cycle();
    endtask

    task automatic serve(input int dly, input logic exp_w, input logic stray, input string tag);
        int t = 0;
        logic [7:0] wd_exp;
        wd_exp = exp_w ? WD : bus.cmd_wdata;
        while (!bus.cmd_valid && t < 100) begin cycle(); t++; end
        n_tests++;
        if (bus.cmd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_cmd_wait: cmd_valid=%b required 1", tag, bus.cmd_valid);
        end else begin
            bus.rsp_valid = stray;
            bus.rsp_rdata = 8'h5A;
            repeat (dly + 1) begin
                if (!exp_w) wd_exp = bus.cmd_wdata;
                n_tests++;
                if ({bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata} !==
                    {1'b1, exp_w, ADDR, wd_exp}) begin
                    n_fail++;
                    $display("FAIL %s_cmd_fields: got v=%b w=%b a=%h d=%h required v=1 w=%b a=%h d=%h",
                             tag, bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata,
                             exp_w, ADDR, wd_exp);
                end
                if (t++ >= 0 && dly > 0) begin
                    dly--;
                    cycle();
                end
            end
            bus.cmd_ready = 1'b1;
            cycle();
            bus.cmd_ready = 1'b0;
            bus.rsp_valid = 1'b0;
            n_tests++;
            if (bus.cmd_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_after_hs: cmd_valid=%b busy=%b required 0/1", tag, bus.cmd_valid, busy);
            end
        end
    endtask

    task automatic respond(input int dly, input logic [7:0] rdata);
        repeat (dly) cycle();
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = rdata;
        cycle();
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        exp_leds = 8'h00;
        exp_err  = 1'b0;
        n_tests++;
        if (leds !== 8'h00) begin n_fail++; $display("FAIL reset_leds: got %h required 00", leds); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
        n_tests++;
        if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", bus.cmd_valid); end
    endtask

    task automatic test_bounce();
        int v0 = valid_cycles;
        for (int i = 0; i < 10; i++) begin btn_trigger = ~btn_trigger; cycle(); end
        for (int i = 0; i < 8; i++) begin
            btn_trigger = 1'b1;
            repeat ($urandom_range(1, DB - 1)) cycle();
            btn_trigger = 1'b0;
            repeat ($urandom_range(1, 3)) cycle();
        end
        btn_trigger = 1'b0;
        for (int i = 0; i < 5; i++) respond(2, 8'($urandom));
        repeat (20) cycle();
        n_tests++;
        if (valid_cycles != v0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce: valid cycles=%0d busy=%b required 0/0", valid_cycles - v0, busy);
        end
        n_tests++;
        if (leds !== exp_leds || err !== exp_err) begin
            n_fail++;
            $display("FAIL idle_rsp: leds=%h err=%b required %h/%b", leds, err, exp_leds, exp_err);
        end
    endtask

    task automatic run_seq(input int rdy_w, input int rdy_r, input int dl_w, input int dl_r,
                           input logic [7:0] rdata, input logic stray, input string tag);
        int h0 = hs_count;
        press();
        serve(rdy_w, 1'b1, stray, {tag, "_wr"});
        respond(dl_w, 8'($urandom));
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_mid: got %b required 1", tag, busy); end
        serve(rdy_r, 1'b0, stray, {tag, "_rd"});
        respond(dl_r, rdata);
        exp_leds = rdata;
        exp_err  = exp_err | (rdata != WD);
        n_tests++;
        if (leds !== exp_leds || err !== exp_err || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_result: leds=%h err=%b busy=%b required %h/%b/0",
                     tag, leds, err, busy, exp_leds, exp_err);
        end
        n_tests++;
        if (hs_count - h0 != 2) begin
            n_fail++;
            $display("FAIL %s_hs_count: got %0d required 2", tag, hs_count - h0);
        end
    endtask

    task automatic test_normal();
        run_seq(0, 0, 4, 4, WD, 1'b0, "normal");
    endtask

    task automatic test_backpressure();
        run_seq(7, 7, 4, 4, WD, 1'b0, "backpressure");
    endtask

    task automatic test_mismatch_busy_press();
        int h0 = hs_count;
        press();
        serve(0, 1'b1, 1'b0, "mm_wr");
        respond(2, 8'h00);
        serve(0, 1'b0, 1'b0, "mm_rd");
        press();
        respond(1, 8'h3C);
        exp_leds = 8'h3C;
        exp_err  = 1'b1;
        repeat (30) cycle();
        n_tests++;
        if (leds !== exp_leds || err !== exp_err) begin
            n_fail++;
            $display("FAIL mismatch_result: leds=%h err=%b required %h/%b", leds, err, exp_leds, exp_err);
        end
        n_tests++;
        if (hs_count - h0 != 2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_press_dropped: handshakes=%0d busy=%b required 2/0", hs_count - h0, busy);
        end
    endtask

    task automatic test_random();
        logic [7:0] rd;
        test_reset();
        for (int it = 0; it < 8; it++) begin
            rd = ($urandom_range(0, 2) == 0) ? 8'($urandom) : WD;
            run_seq($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 6),
                    $urandom_range(0, 6), rd, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_reset_mid();
        press();
        n_tests++;
        if (bus.cmd_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: cmd_valid=%b required 1", bus.cmd_valid); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_leds = 8'h00;
        exp_err  = 1'b0;
        n_tests++;
        if ({bus.cmd_valid, busy, leds, err} !== {1'b0, 1'b0, exp_leds, exp_err}) begin
            n_fail++;
            $display("FAIL rstmid: valid=%b busy=%b leds=%h err=%b required 0/0/00/0",
                     bus.cmd_valid, busy, leds, err);
        end
    endtask

    task automatic test_timeout();
        int k = 0;
        int h0;
        test_reset();
        h0 = hs_count;
        press();
        serve(0, 1'b1, 1'b0, "to_wr");
`ifdef TRIG_SEQ_TIMEOUT_EN
        while (busy && k < 100) begin cycle(); k++; end
        n_tests++;
        if (k < TO || k > TO + 1 || busy !== 1'b0 || err !== 1'b1 || leds !== exp_leds) begin
            n_fail++;
            $display("FAIL timeout: cycles=%0d busy=%b err=%b leds=%h required %0d/0/1/%h",
                     k, busy, err, leds, TO, exp_leds);
        end
        repeat (20) cycle();
        n_tests++;
        if (hs_count - h0 != 1) begin
            n_fail++;
            $display("FAIL timeout_no_read: handshakes=%0d required 1", hs_count - h0);
        end
`else
        repeat (60) begin cycle(); k++; end
        n_tests++;
        if (busy !== 1'b1 || err !== 1'b0 || bus.cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_forever: busy=%b err=%b valid=%b after %0d cycles required 1/0/0",
                     busy, err, bus.cmd_valid, k);
        end
        respond(0, 8'h00);
        serve(0, 1'b0, 1'b0, "to_rd");
        respond(0, WD);
        exp_leds = WD;
        n_tests++;
        if (busy !== 1'b0 || err !== 1'b0 || leds !== exp_leds || hs_count - h0 != 2) begin
            n_fail++;
            $display("FAIL wait_complete: busy=%b err=%b leds=%h hs=%0d required 0/0/%h/2",
                     busy, err, leds, hs_count - h0, exp_leds);
        end
`endif
    endtask

    initial begin
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 8'h00;
        test_reset();
        test_bounce();
        test_normal();
        test_backpressure();
        test_mismatch_busy_press();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
`default_nettype wire
